// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter feeding one UART byte transmitter
// Watchdog aborts a stalled source or hung transmitter and raises a sticky error.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535,
  parameter int TW         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  output logic [IDW-1:0]    grant_id_o,
  output logic              active_o,
  output logic              timeout_err_o,
  input  logic              err_clr_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            last_q, last_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            pick_found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  next_ptr;
  logic            xfer;
  int              idx;

  // Scan downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  assign next_ptr = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    last_d      = last_q;
    cnt_d       = cnt_q;
    err_d       = err_q & ~err_clr_i;
    req_ready_o = '0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        req_ready_o[grant_q] = ~tx_busy_i;
        xfer = req_valid_i[grant_q] & ~tx_busy_i;
        if (xfer) begin
          tx_data_d  = req_data_i[8*grant_q +: 8];
          last_d     = req_last_i[grant_q];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as success.
        if (tx_done_i) begin
          cnt_d = '0;
          if (last_q) begin
            rr_ptr_d = next_ptr;
            state_d  = GAP;
          end else begin
            state_d = ISSUE;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_q;
  assign active_o      = (state_q != IDLE);
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter
// Byte sources and a 10-cycle transmitter are modelled in the bench; the DUT uses TIMEOUT=100.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int FRAME = 10;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [8*NREQ-1:0] req_data_i = '0;
  logic [NREQ-1:0]   req_last_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic              tx_start_o;
  logic [7:0]        tx_data_o;
  logic              tx_busy_i;
  logic              tx_done_i = 1'b0;
  logic [1:0]        grant_id_o;
  logic              active_o;
  logic              timeout_err_o;
  logic              err_clr_i = 1'b0;

  logic tx_busy_m = 1'b0;
  logic force_busy = 1'b0;
  logic tx_hang = 1'b0;
  int   tx_cnt = 0;
  assign tx_busy_i = tx_busy_m | force_busy;

  logic [7:0] txq[$];
  logic [1:0] gq[$];

  logic [7:0] src_bytes[NREQ][4];
  int src_len[NREQ];
  int src_pos[NREQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc, ready0_cyc, done_at_ready0, start_cyc, err_cyc, idle_cyc;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(2), .GAP_CYCLES(16), .TIMEOUT(100), .TW(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
    .grant_id_o(grant_id_o), .active_o(active_o), .timeout_err_o(timeout_err_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for FRAME cycles after each start, then a done pulse unless hung.
  always @(negedge clk) begin
    tx_done_i = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        tx_busy_m = 1'b0;
        if (!tx_hang) tx_done_i = 1'b1;
      end
    end else if (tx_start_o) begin
      tx_busy_m = 1'b1;
      tx_cnt = FRAME;
      txq.push_back(tx_data_o);
      gq.push_back(grant_id_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sources();
    for (int s = 0; s < NREQ; s++) begin
      if (src_pos[s] < src_len[s]) begin
        req_valid_i[s] = 1'b1;
        req_data_i[8*s +: 8] = src_bytes[s][src_pos[s]];
        req_last_i[s] = (src_pos[s] == src_len[s] - 1);
      end else begin
        req_valid_i[s] = 1'b0;
        req_data_i[8*s +: 8] = 8'h00;
        req_last_i[s] = 1'b0;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < NREQ; s++) begin
      src_len[s] = 0;
      src_pos[s] = 0;
      for (int b = 0; b < 4; b++) src_bytes[s][b] = 8'h00;
    end
    drive_sources();
    txq.delete();
    gq.delete();
  endtask

  task automatic clear_track();
    last_done_cyc = -1;
    ready0_cyc = -1;
    done_at_ready0 = -1;
    start_cyc = -1;
    err_cyc = -1;
    idle_cyc = -1;
  endtask

  task automatic step_srcs();
    logic [NREQ-1:0] x;
    x = req_valid_i & req_ready_o;
    step();
    cyc++;
    for (int s = 0; s < NREQ; s++) if (x[s]) src_pos[s]++;
    drive_sources();
    if (tx_done_i) last_done_cyc = cyc;
    if (req_ready_o[0] && ready0_cyc < 0) begin
      ready0_cyc = cyc;
      done_at_ready0 = last_done_cyc;
    end
    if (tx_start_o && start_cyc < 0) start_cyc = cyc;
    if (timeout_err_o && err_cyc < 0) err_cyc = cyc;
    if (!active_o && idle_cyc < 0 && last_done_cyc >= 0) idle_cyc = cyc;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && !(txq.size() >= n && !active_o && req_valid_i == '0)) begin
      step_srcs();
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    clear_srcs();
    clear_track();
    step();
    step();
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_start", 32'(tx_start_o), 32'h0);
    check("rst_data", 32'(tx_data_o), 32'h0);
    check("rst_grant", 32'(grant_id_o), 32'h0);
    check("rst_active", 32'(active_o), 32'h0);
    check("rst_err", 32'(timeout_err_o), 32'h0);
    rst_i = 1'b0;

    // 1: single byte from source 0
    src_len[0] = 1; src_bytes[0][0] = 8'h55;
    drive_sources();
    check("t1_ready_idle", 32'(req_ready_o), 32'h0);
    step_srcs();
    check("t1_active", 32'(active_o), 32'h1);
    check("t1_grant", 32'(grant_id_o), 32'h0);
    check("t1_ready", 32'(req_ready_o), 32'h1);
    step_srcs();
    check("t1_start", 32'(tx_start_o), 32'h1);
    check("t1_data", 32'(tx_data_o), 32'h55);
    check("t1_ready_off", 32'(req_ready_o), 32'h0);
    step_srcs();
    check("t1_start_pulse", 32'(tx_start_o), 32'h0);
    run_until(1, 200, "t1_budget");
    check("t1_gap_len", 32'(idle_cyc - last_done_cyc), 32'd16);
    check("t1_count", 32'(txq.size()), 32'd1);

    // 2: all four single-byte packets, then only 1 and 3
    clear_srcs();
    do_reset();
    for (int s = 0; s < NREQ; s++) begin
      src_len[s] = 1;
      src_bytes[s][0] = 8'hA0 + 8'(s);
    end
    drive_sources();
    run_until(4, 400, "t2_budget");
    check("t2_count", 32'(txq.size()), 32'd4);
    check("t2_b0", 32'(txq[0]), 32'hA0);
    check("t2_b1", 32'(txq[1]), 32'hA1);
    check("t2_b2", 32'(txq[2]), 32'hA2);
    check("t2_b3", 32'(txq[3]), 32'hA3);
    clear_srcs();
    do_reset();
    src_len[1] = 1; src_bytes[1][0] = 8'hB1;
    src_len[3] = 1; src_bytes[3][0] = 8'hB3;
    drive_sources();
    run_until(2, 200, "t2b_budget");
    check("t2b_g0", 32'(gq[0]), 32'd1);
    check("t2b_g1", 32'(gq[1]), 32'd3);
    check("t2b_b1", 32'(txq[1]), 32'hB3);

    // 3: 3-byte packet from source 2 holds off source 0
    clear_srcs();
    clear_track();
    do_reset();
    src_len[2] = 3;
    src_bytes[2][0] = 8'hC0; src_bytes[2][1] = 8'hC1; src_bytes[2][2] = 8'hC2;
    drive_sources();
    step_srcs();
    src_len[0] = 1; src_bytes[0][0] = 8'hD0;
    drive_sources();
    run_until(4, 400, "t3_budget");
    check("t3_b0", 32'(txq[0]), 32'hC0);
    check("t3_b1", 32'(txq[1]), 32'hC1);
    check("t3_b2", 32'(txq[2]), 32'hC2);
    check("t3_b3", 32'(txq[3]), 32'hD0);
    check("t3_g1", 32'(gq[1]), 32'd2);
    check("t3_ready0_after_gap", 32'(ready0_cyc - done_at_ready0), 32'd17);

    // 4: hung transmitter, watchdog, next requester, err_clr
    clear_srcs();
    clear_track();
    tx_hang = 1'b1;
    src_len[1] = 1; src_bytes[1][0] = 8'h41;
    src_len[3] = 1; src_bytes[3][0] = 8'h43;
    drive_sources();
    run_until(2, 600, "t4_budget");
    check("t4_err_time", 32'(err_cyc - start_cyc), 32'd100);
    check("t4_g0", 32'(gq[0]), 32'd1);
    check("t4_g1", 32'(gq[1]), 32'd3);
    check("t4_b1", 32'(txq[1]), 32'h43);
    check("t4_err_sticky", 32'(timeout_err_o), 32'h1);
    tx_hang = 1'b0;
    err_clr_i = 1'b1;
    step_srcs();
    err_clr_i = 1'b0;
    check("t4_err_clr", 32'(timeout_err_o), 32'h0);

    // 5: tx_busy held 50 cycles in ISSUE
    clear_srcs();
    force_busy = 1'b1;
    src_len[0] = 1; src_bytes[0][0] = 8'h5A;
    drive_sources();
    step_srcs();
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        if (req_ready_o != '0) bad++;
        step_srcs();
      end
      check("t5_ready_stalled", 32'(bad), 32'd0);
    end
    force_busy = 1'b0;
    #1;
    check("t5_ready_release", 32'(req_ready_o), 32'h1);
    step_srcs();
    check("t5_start", 32'(tx_start_o), 32'h1);
    check("t5_data", 32'(tx_data_o), 32'h5A);
    check("t5_no_err", 32'(timeout_err_o), 32'h0);
    run_until(1, 200, "t5_budget");

    // 6: reset pulsed in WAIT_DONE
    clear_srcs();
    src_len[2] = 1; src_bytes[2][0] = 8'h62;
    drive_sources();
    step_srcs();
    step_srcs();
    step_srcs();
    step_srcs();
    src_len[0] = 1; src_bytes[0][0] = 8'h60;
    src_len[1] = 1; src_bytes[1][0] = 8'h61;
    drive_sources();
    rst_i = 1'b1;
    step_srcs();
    rst_i = 1'b0;
    check("t6_ready", 32'(req_ready_o), 32'h0);
    check("t6_start", 32'(tx_start_o), 32'h0);
    check("t6_data", 32'(tx_data_o), 32'h0);
    check("t6_grant", 32'(grant_id_o), 32'h0);
    check("t6_active", 32'(active_o), 32'h0);
    step_srcs();
    check("t6_regrant", 32'(grant_id_o), 32'h0);
    check("t6_wait_busy", 32'(req_ready_o), 32'h0);
    run_until(3, 400, "t6_budget");
    check("t6_b0", 32'(txq[0]), 32'h62);
    check("t6_b1", 32'(txq[1]), 32'h60);
    check("t6_b2", 32'(txq[2]), 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
